npu_pool_writer: RTL and testbench
==================================

# npu_pool_writer

Post-MAC output stage of the NPU datapath. Consumes the quantized `mac_out`/`mac_valid` stream produced by `npu_mac` in raster order (row-major, one value per output pixel), applies optional ReLU and optional 2x2 stride-2 max pooling, and writes results sequentially into the activation memory for the next layer. Frame geometry and destination base address are programmed per layer by the layer controller.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of activation values (matches `npu_mac`).
- `ADDR_WIDTH`, 12, activation memory address width.
- `MAX_WIDTH`, 64, maximum conv output width; line buffer depth is `MAX_WIDTH/2`.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `frame_start`  input  1  one-cycle pulse; arms the block for a new output frame and latches config.
- `relu_en`  input  1  1 = clamp negatives to 0.
- `pool_en`  input  1  1 = 2x2 max pool, 0 = pass-through.
- `img_width`  input  7  conv output width in pixels (1..`MAX_WIDTH`).
- `img_height`  input  7  conv output height in rows (1..127).
- `wr_base`  input  `ADDR_WIDTH`  first destination address.
- `mac_valid`  input  1  `mac_out` valid this cycle.
- `mac_out`  input  signed `DATA_WIDTH`  MAC result.
- `act_wr_en`  output  1  activation memory write strobe.
- `act_wr_addr`  output  `ADDR_WIDTH`  write address.
- `act_wr_data`  output  signed `DATA_WIDTH`  write data.
- `frame_done`  output  1  one-cycle pulse after the last write of the frame.
- `busy`  output  1  high from `frame_start` until `frame_done`.
- `stray_valid`  output  1  sticky; set when `mac_valid` arrives while IDLE; cleared by `frame_start`.

## Operation
- States: IDLE, RUN, FLUSH. IDLE -> RUN on `frame_start` (config latched). RUN -> FLUSH when the last input pixel (row `img_height-1`, col `img_width-1`) is accepted. FLUSH -> IDLE after one cycle, asserting `frame_done`.
- `frame_start` in RUN/FLUSH: abort current frame, relatch config, clear counters, restart in RUN; no `frame_done` for the aborted frame.
- Counters `col`, `row` advance only on `mac_valid` in RUN; `col` wraps to 0 at `img_width-1` and increments `row`.
- ReLU: `v = (relu_en && mac_out < 0) ? 0 : mac_out`; applied before pooling.
- Pass-through (`pool_en=0`): every accepted value written; address `wr_base + n`, n = 0.. W*H-1.
- Pooling (`pool_en=1`): even col latches `v` in a pair register; odd col forms `hmax = max(pair, v)`. Even row: `hmax` stored to line buffer at `col>>1`. Odd row: write `max(linebuf[col>>1], hmax)`. Output count `floor(W/2)*floor(H/2)`, addresses consecutive from `wr_base`.
- Odd W: last column of each row ignored. Odd H: last row consumed but not written.
- Comparisons are signed; no arithmetic width growth (max only). Address wraps modulo 2^`ADDR_WIDTH`.
- `mac_valid` in IDLE: dropped, `stray_valid` set.

## Timing
- Reset values: `act_wr_en`=0, `act_wr_addr`=0, `act_wr_data`=0, `frame_done`=0, `busy`=0, `stray_valid`=0; state IDLE, counters 0.
- Latency: write appears registered 1 cycle after the `mac_valid` that completes it (every input in pass-through; odd-col/odd-row input in pooling).
- Line buffer read is issued on the even-col input of an odd row so data is ready at the odd-col input; back-to-back `mac_valid` every cycle must be sustained with no stalls.
- `frame_done` asserts the cycle after the final write (or after the final accepted input if it produces no write); `busy` deasserts the same cycle.
- `frame_start` coincident with `mac_valid`: `mac_valid` belongs to the new frame as pixel (0,0).

## Structure
- Shared package `npu_pkg`: state encoding (IDLE/RUN/FLUSH), `DATA_WIDTH`, `ADDR_WIDTH`, `MAX_WIDTH` defaults.
- Sub-module `npu_line_buf`: simple dual-port RAM, `MAX_WIDTH/2` x `DATA_WIDTH`, synchronous read, one write port; no reset on contents.

## Test plan
- Pass-through, W=4, H=2, relu off, inputs -3..4, base 0x100 -> 8 writes, addr 0x100..0x107, data -3..4, `frame_done` 1 cycle after last.
- ReLU on, pass-through, inputs {-128, -1, 0, 127} -> data {0, 0, 0, 127}.
- Pool, W=4, H=2, rows {1,5,-2,3},{4,2,7,-8}, relu off -> 2 writes: 5, 7 at base, base+1.
- Pool, W=5, H=3 continuous valid -> 2 writes only; column 4 and row 2 ignored; `busy` drops after 15th input.
- `frame_start` after 3 inputs of a frame, then full W=2,H=2 pool frame {-4,-9,-6,-5}, relu off -> single write -4 at `wr_base`, one `frame_done`.
- `mac_valid` in IDLE -> no write, `stray_valid`=1; next `frame_start` clears it; async `rst` low mid-frame -> all outputs to reset values immediately.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths and the pool writer state encoding.
package npu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 12;
    localparam int MAX_WIDTH  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } pool_state_t;

endpackage

// File: rtl/npu_line_buf.sv
// Simple dual-port line buffer holding one horizontally pooled row; registered read, contents not reset.
module npu_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         rd_en,
    input  logic [AW-1:0]                rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data holds until the next read so gaps in the input stream are harmless.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/npu_pool_writer.sv
// Post-MAC output stage: optional ReLU and 2x2 stride-2 max pooling, sequential writes to activation memory.
module npu_pool_writer #(
    parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = npu_pkg::ADDR_WIDTH,
    parameter int MAX_WIDTH  = npu_pkg::MAX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         relu_en,
    input  logic                         pool_en,
    input  logic [6:0]                   img_width,
    input  logic [6:0]                   img_height,
    input  logic [ADDR_WIDTH-1:0]        wr_base,
    input  logic                         mac_valid,
    input  logic signed [DATA_WIDTH-1:0] mac_out,
    output logic                         act_wr_en,
    output logic [ADDR_WIDTH-1:0]        act_wr_addr,
    output logic signed [DATA_WIDTH-1:0] act_wr_data,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         stray_valid
);
    import npu_pkg::*;

    localparam int LB_DEPTH = MAX_WIDTH / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    pool_state_t state, state_n;

    logic                         relu_q, pool_q;
    logic [6:0]                   width_q, height_q;
    logic [ADDR_WIDTH-1:0]        base_q;
    logic [6:0]                   col, row;
    logic [ADDR_WIDTH-1:0]        wr_cnt;
    logic signed [DATA_WIDTH-1:0] pair;

    logic                         eff_relu, eff_pool;
    logic [6:0]                   eff_w, eff_h, cur_col, cur_row;
    logic [ADDR_WIDTH-1:0]        eff_base, cur_cnt;
    logic                         accept, last_col, last_row, do_write, done_n;
    logic                         lb_we, lb_re;
    logic signed [DATA_WIDTH-1:0] v, hmax, vmax, wr_val, lb_rd_data;

    // A frame_start pulse takes effect immediately, so a coincident mac_valid is pixel (0,0) of the new frame.
    always_comb begin
        eff_relu = frame_start ? relu_en    : relu_q;
        eff_pool = frame_start ? pool_en    : pool_q;
        eff_w    = frame_start ? img_width  : width_q;
        eff_h    = frame_start ? img_height : height_q;
        eff_base = frame_start ? wr_base    : base_q;
        cur_col  = frame_start ? '0 : col;
        cur_row  = frame_start ? '0 : row;
        cur_cnt  = frame_start ? '0 : wr_cnt;
        accept   = mac_valid && (frame_start || state == ST_RUN);
        last_col = (cur_col == eff_w - 7'd1);
        last_row = (cur_row == eff_h - 7'd1);
        v        = (eff_relu && mac_out < 0) ? '0 : mac_out;
        hmax     = (v > pair) ? v : pair;
        vmax     = (lb_rd_data > hmax) ? lb_rd_data : hmax;
        wr_val   = eff_pool ? vmax : v;
        do_write = accept && (!eff_pool || (cur_col[0] && cur_row[0]));
        lb_we    = accept && eff_pool && cur_col[0] && !cur_row[0];
        lb_re    = accept && eff_pool && !cur_col[0] && cur_row[0];
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        unique case (state)
            ST_IDLE:  state_n = ST_IDLE;
            ST_RUN:   state_n = ST_RUN;
            ST_FLUSH: begin
                state_n = ST_IDLE;
                done_n  = !frame_start;
            end
            default:  state_n = ST_IDLE;
        endcase
        if (frame_start) begin
            state_n = ST_RUN;
        end
        if (accept && last_col && last_row) begin
            state_n = ST_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            relu_q   <= 1'b0;
            pool_q   <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            base_q   <= '0;
            col      <= '0;
            row      <= '0;
            wr_cnt   <= '0;
            pair     <= '0;
        end else begin
            if (frame_start) begin
                relu_q   <= relu_en;
                pool_q   <= pool_en;
                width_q  <= img_width;
                height_q <= img_height;
                base_q   <= wr_base;
                col      <= '0;
                row      <= '0;
                wr_cnt   <= '0;
            end
            if (accept) begin
                col <= last_col ? 7'd0 : cur_col + 7'd1;
                row <= last_col ? cur_row + 7'd1 : cur_row;
                if (eff_pool && !cur_col[0]) begin
                    pair <= v;
                end
            end
            if (do_write) begin
                wr_cnt <= cur_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_wr_en   <= 1'b0;
            act_wr_addr <= '0;
            act_wr_data <= '0;
            frame_done  <= 1'b0;
            stray_valid <= 1'b0;
        end else begin
            act_wr_en  <= do_write;
            frame_done <= done_n;
            if (do_write) begin
                act_wr_addr <= eff_base + cur_cnt;
                act_wr_data <= wr_val;
            end
            if (frame_start) begin
                stray_valid <= 1'b0;
            end else if (mac_valid && state == ST_IDLE) begin
                stray_valid <= 1'b1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    npu_line_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (LB_DEPTH)
    ) u_line_buf (
        .clk    (clk),
        .wr_en  (lb_we),
        .wr_addr(cur_col[LB_AW:1]),
        .wr_data(hmax),
        .rd_en  (lb_re),
        .rd_addr(cur_col[LB_AW:1]),
        .rd_data(lb_rd_data)
    );

endmodule

// File: tb/tb_npu_pool_writer.sv
// Self-checking bench for npu_pool_writer: directed scenarios plus random frames against a 2D reference model.
module tb_npu_pool_writer;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_start = 1'b0;
    logic              relu_en = 1'b0;
    logic              pool_en = 1'b0;
    logic [6:0]        img_width = '0;
    logic [6:0]        img_height = '0;
    logic [11:0]       wr_base = '0;
    logic              mac_valid = 1'b0;
    logic signed [7:0] mac_out = '0;
    logic              act_wr_en;
    logic [11:0]       act_wr_addr;
    logic signed [7:0] act_wr_data;
    logic              frame_done;
    logic              busy;
    logic              stray_valid;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int pix[$];
    int expAddr[$];
    int expData[$];

    npu_pool_writer dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .relu_en    (relu_en),
        .pool_en    (pool_en),
        .img_width  (img_width),
        .img_height (img_height),
        .wr_base    (wr_base),
        .mac_valid  (mac_valid),
        .mac_out    (mac_out),
        .act_wr_en  (act_wr_en),
        .act_wr_addr(act_wr_addr),
        .act_wr_data(act_wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .stray_valid(stray_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Every write strobe must match the next entry of the reference write list.
    always @(negedge clk) begin
        if (frame_done) doneCount++;
        if (act_wr_en) begin
            if (expAddr.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                checkOutput("wr_addr", int'(act_wr_addr), expAddr.pop_front());
                checkOutput("wr_data", int'(act_wr_data), expData.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int reluOf(input int x, input bit r);
        return (r && x < 0) ? 0 : x;
    endfunction

    task automatic buildExpected(input int w, input int h, input bit relu, input bit pool, input int base);
        if (!pool) begin
            for (int n = 0; n < w * h; n++) begin
                expAddr.push_back((base + n) % 4096);
                expData.push_back(reluOf(pix[n], relu));
            end
        end else begin
            for (int r = 0; r < h / 2; r++) begin
                for (int c = 0; c < w / 2; c++) begin
                    int m;
                    m = reluOf(pix[2 * r * w + 2 * c], relu);
                    for (int d = 1; d < 4; d++) begin
                        int x;
                        x = reluOf(pix[(2 * r + d / 2) * w + 2 * c + d % 2], relu);
                        if (x > m) m = x;
                    end
                    expAddr.push_back((base + r * (w / 2) + c) % 4096);
                    expData.push_back(m);
                end
            end
        end
    endtask

    // Runs one complete frame from the pixels currently in pix, with optional random input gaps.
    task automatic applyStimulus(input int w, input int h, input bit relu, input bit pool,
                                 input int base, input int gapPct, input bit coincident);
        int idx;
        int doneBefore;
        buildExpected(w, h, relu, pool, base);
        doneBefore  = doneCount;
        frame_start = 1'b1;
        relu_en     = relu;
        pool_en     = pool;
        img_width   = 7'(w);
        img_height  = 7'(h);
        wr_base     = 12'(base);
        idx         = 0;
        mac_valid   = coincident;
        if (coincident) begin
            mac_out = 8'(pix[0]);
            idx     = 1;
        end
        step();
        frame_start = 1'b0;
        checkOutput("stray_cleared", int'(stray_valid), 0);
        checkOutput("busy_running", int'(busy), 1);
        while (idx < w * h) begin
            if (int'($urandom_range(0, 99)) < gapPct) begin
                mac_valid = 1'b0;
            end else begin
                mac_valid = 1'b1;
                mac_out   = 8'(pix[idx]);
                idx++;
            end
            step();
        end
        mac_valid = 1'b0;
        checkOutput("busy_flush", int'(busy), 1);
        checkOutput("done_early", int'(frame_done), 0);
        step();
        checkOutput("done_pulse", int'(frame_done), 1);
        checkOutput("busy_idle", int'(busy), 0);
        step();
        checkOutput("done_width", int'(frame_done), 0);
        checkOutput("pending_writes", expAddr.size(), 0);
        checkOutput("done_count", doneCount - doneBefore, 1);
        expAddr.delete();
        expData.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w, h;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_en", int'(act_wr_en), 0);
        checkOutput("rst_wr_addr", int'(act_wr_addr), 0);
        checkOutput("rst_wr_data", int'(act_wr_data), 0);
        checkOutput("rst_done", int'(frame_done), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_stray", int'(stray_valid), 0);
        rst = 1'b1;
        step();

        // Pass-through ramp, then ReLU corner values.
        pix = '{-3, -2, -1, 0, 1, 2, 3, 4};
        applyStimulus(4, 2, 1'b0, 1'b0, 'h100, 0, 1'b0);
        pix = '{-128, -1, 0, 127};
        applyStimulus(4, 1, 1'b1, 1'b0, 'h020, 0, 1'b0);

        // Pooling with known maxima, and odd dimensions with continuous valid.
        pix = '{1, 5, -2, 3, 4, 2, 7, -8};
        applyStimulus(4, 2, 1'b0, 1'b1, 'h040, 0, 1'b0);
        pix.delete();
        for (int i = 0; i < 15; i++) pix.push_back(int'($urandom_range(0, 255)) - 128);
        applyStimulus(5, 3, 1'b0, 1'b1, 'h050, 0, 1'b0);

        // Stray valid while idle is dropped and flagged.
        mac_valid = 1'b1;
        mac_out   = 8'sd55;
        step();
        mac_valid = 1'b0;
        checkOutput("stray_set", int'(stray_valid), 1);
        step();

        // Abort a frame after three inputs, then restart with a 2x2 pooled frame.
        frame_start = 1'b1;
        pool_en     = 1'b1;
        relu_en     = 1'b0;
        img_width   = 7'd4;
        img_height  = 7'd4;
        wr_base     = 12'h300;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mac_valid = 1'b1;
            mac_out   = 8'(i * 20 + 3);
            step();
        end
        mac_valid = 1'b0;
        pix = '{-4, -9, -6, -5};
        applyStimulus(2, 2, 1'b0, 1'b1, 'h310, 0, 1'b0);

        // Random frames: geometry, modes, base near wrap, gaps and coincident start.
        for (int f = 0; f < 20; f++) begin
            w = int'($urandom_range(1, 20));
            h = int'($urandom_range(1, 12));
            if (f == 0) w = 64;
            pix.delete();
            for (int i = 0; i < w * h; i++) pix.push_back(int'($urandom_range(0, 255)) - 128);
            applyStimulus(w, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          (f % 4 == 0) ? int'($urandom_range(4080, 4095)) : int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a pass-through frame.
        pix = '{10, 20, 30, 40, 50, 60};
        buildExpected(6, 1, 1'b0, 1'b0, 'h080);
        frame_start = 1'b1;
        pool_en     = 1'b0;
        img_width   = 7'd6;
        img_height  = 7'd1;
        wr_base     = 12'h080;
        mac_valid   = 1'b1;
        mac_out     = 8'sd10;
        step();
        frame_start = 1'b0;
        mac_out     = 8'sd20;
        step();
        mac_valid = 1'b0;
        checkOutput("pre_rst_wr_en", int'(act_wr_en), 1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_wr_en", int'(act_wr_en), 0);
        checkOutput("async_wr_addr", int'(act_wr_addr), 0);
        checkOutput("async_wr_data", int'(act_wr_data), 0);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_done", int'(frame_done), 0);
        checkOutput("async_stray", int'(stray_valid), 0);
        expAddr.delete();
        expData.delete();
        step();
        rst = 1'b1;
        step();
        checkOutput("post_rst_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
